wb_regfile: RTL and testbench

- Write-back stage and architectural register file. Sits downstream of the MEM/WB pipeline register and is the consumer end of its valid/ready/allow-in handshake.
- Selects the write-back value: the load result, or the ALU result carried on the address bus.
- Aligns and sign/zero-extends load data, commits to a 32-entry register file, and counts retired instructions.
- Traps misaligned loads with a stall-until-acknowledge state machine.

---
 rtl/wb_regfile.sv | 139 +++++++++++++
 tb/tb_wb_regfile.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage + 32-entry register file: aligns loads, commits rd, counts retired instrs, traps misaligned loads.
// Latency: write lands at the clock edge of fire; reads are combinational (same-cycle forward with WB_REGFILE_BYPASS_EN).
// Backpressure: allow_in_regfile drops while a misaligned-load trap is pending; upstream holds until err_ack.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int RD_WIDTH   = 5,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_wb,
    input  logic                  ready_go_wb,
    output logic                  allow_in_regfile,
    input  logic                  write_reg,
    input  logic                  mem2reg,
    input  logic [RD_WIDTH-1:0]   rd_wb,
    input  logic [2:0]            ins_func3,
    input  logic [BUS_WIDTH-1:0]  mem_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic [RD_WIDTH-1:0]   rs1_addr,
    input  logic [RD_WIDTH-1:0]   rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [63:0]           instret,
    output logic                  misalign_err,
    output logic [BUS_WIDTH-1:0]  err_addr,
    input  logic                  err_ack
);

    typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  fire;
    logic                  misaligned;
    logic                  commit;
    logic                  commit_wr;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] wb_data;

    assign allow_in_regfile = (state == RUN);
    assign fire             = valid_wb & ready_go_wb & allow_in_regfile;

    // Halfword loads need addr[0]=0; word loads need addr[1:0]=0. Byte loads never trap.
    assign misaligned = mem2reg &
                        (((ins_func3[1:0] == 2'b01) & mem_address[0]) |
                         ((ins_func3[1:0] == 2'b10) & (mem_address[1:0] != 2'b00)));

    assign commit    = fire & ~misaligned;
    assign commit_wr = commit & write_reg & (rd_wb != '0);

    // Little-endian byte/half lane selection by the low address bits.
    always_comb begin
        ld_byte = mem_read_data[7:0];
        case (mem_address[1:0])
            2'b00:   ld_byte = mem_read_data[7:0];
            2'b01:   ld_byte = mem_read_data[15:8];
            2'b10:   ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = mem_address[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    end

    // Sign/zero extension by load type; unknown codes behave as LW.
    always_comb begin
        case (ins_func3)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_read_data;
        endcase
    end

    // The ALU result travels on the address bus for non-load instructions.
    assign wb_data = mem2reg ? ld_data : mem_address[DATA_WIDTH-1:0];

    // Trap FSM: a misaligned load parks the stage in ERR until software acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            misalign_err <= 1'b0;
            err_addr     <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (fire && misaligned) begin
                        state        <= ERR;
                        misalign_err <= 1'b1;
                        err_addr     <= mem_address;
                    end
                end
                ERR: begin
                    if (err_ack) begin
                        state        <= RUN;
                        misalign_err <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Register file commit; x0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_wr) begin
            regs[rd_wb] <= wb_data;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (commit) begin
            instret <= instret + 64'd1;
        end
    end

    // Combinational read ports, optionally forwarding the value being committed this cycle.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = regs[rs1_addr];
        if (rs2_addr != '0) rs2_data = regs[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit_wr && (rs1_addr == rd_wb)) rs1_data = wb_data;
        if (commit_wr && (rs2_addr == rd_wb)) rs2_data = wb_data;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU/load write-back, x0 and gating, bypass, misaligned trap.
// Inputs change on the falling edge; outputs are sampled #1 after the rising edge or mid-cycle.
// Each scenario task checks its own results inline.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_wb;
    logic        ready_go_wb;
    logic        allow_in_regfile;
    logic        write_reg;
    logic        mem2reg;
    logic [4:0]  rd_wb;
    logic [2:0]  ins_func3;
    logic [31:0] mem_address;
    logic [31:0] mem_read_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [63:0] instret;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic        err_ack;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    wb_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .valid_wb         (valid_wb),
        .ready_go_wb      (ready_go_wb),
        .allow_in_regfile (allow_in_regfile),
        .write_reg        (write_reg),
        .mem2reg          (mem2reg),
        .rd_wb            (rd_wb),
        .ins_func3        (ins_func3),
        .mem_address      (mem_address),
        .mem_read_data    (mem_read_data),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .instret          (instret),
        .misalign_err     (misalign_err),
        .err_addr         (err_addr),
        .err_ack          (err_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Present one instruction for a single cycle, then drop valid.
    task automatic drive_fire(input logic wr, input logic m2r, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        valid_wb      = 1'b1;
        ready_go_wb   = 1'b1;
        write_reg     = wr;
        mem2reg       = m2r;
        rd_wb         = rd;
        ins_func3     = f3;
        mem_address   = addr;
        mem_read_data = data;
        @(posedge clk);
        #1;
        valid_wb = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = i[4:0];
            rs2_addr = 5'(31 - i);
            #1;
            chk_cnt++;
            if (rs1_data !== 32'h0) $display("FAIL reset_rs1[%0d]: got %h expected 0", i, rs1_data);
            else pass_cnt++;
            chk_cnt++;
            if (rs2_data !== 32'h0) $display("FAIL reset_rs2[%0d]: got %h expected 0", 31 - i, rs2_data);
            else pass_cnt++;
        end
        chk_cnt++;
        if (instret !== 64'd0) $display("FAIL reset_instret: got %0d expected 0", instret);
        else pass_cnt++;
        chk_cnt++;
        if (allow_in_regfile !== 1'b1) $display("FAIL reset_allow: got %b expected 1", allow_in_regfile);
        else pass_cnt++;
        chk_cnt++;
        if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", misalign_err);
        else pass_cnt++;
        chk_cnt++;
        if (err_addr !== 32'h0) $display("FAIL reset_err_addr: got %h expected 0", err_addr);
        else pass_cnt++;
    endtask

    task automatic test_alu_write;
        drive_fire(1'b1, 1'b0, 5'd5, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF);
        rs1_addr = 5'd5;
        #1;
        chk_cnt++;
        if (rs1_data !== 32'h1234_5678) $display("FAIL alu_write: got %h expected 12345678", rs1_data);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd1) $display("FAIL alu_instret: got %0d expected 1", instret);
        else pass_cnt++;
    endtask

    task automatic test_loads;
        logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adr_tab [5] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2000};
        logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive_fire(1'b1, 1'b1, 5'(10 + i), f3_tab[i], adr_tab[i], 32'h80FF_7F01);
            rs2_addr = 5'(10 + i);
            #1;
            chk_cnt++;
            if (rs2_data !== exp_tab[i])
                $display("FAIL load[%0d] f3=%b: got %h expected %h", i, f3_tab[i], rs2_data, exp_tab[i]);
            else pass_cnt++;
            chk_cnt++;
            if (allow_in_regfile !== 1'b1) $display("FAIL load_allow[%0d]: got %b expected 1", i, allow_in_regfile);
            else pass_cnt++;
        end
        chk_cnt++;
        if (instret !== 64'd6) $display("FAIL load_instret: got %0d expected 6", instret);
        else pass_cnt++;
    endtask

    task automatic test_x0_gating;
        drive_fire(1'b1, 1'b0, 5'd0, 3'b010, 32'hDEAD_BEEF, 32'h0);
        rs1_addr = 5'd0;
        #1;
        chk_cnt++;
        if (rs1_data !== 32'h0) $display("FAIL x0_write: got %h expected 0", rs1_data);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd7) $display("FAIL x0_instret: got %0d expected 7", instret);
        else pass_cnt++;
        // valid without ready_go, then ready_go without valid: neither may commit.
        @(negedge clk);
        valid_wb    = 1'b1;
        ready_go_wb = 1'b0;
        write_reg   = 1'b1;
        mem2reg     = 1'b0;
        rd_wb       = 5'd5;
        mem_address = 32'hFFFF_0000;
        @(negedge clk);
        valid_wb    = 1'b0;
        ready_go_wb = 1'b1;
        @(posedge clk);
        #1;
        rs1_addr = 5'd5;
        #1;
        chk_cnt++;
        if (rs1_data !== 32'h1234_5678) $display("FAIL gated_write: got %h expected 12345678", rs1_data);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd7) $display("FAIL gated_instret: got %0d expected 7", instret);
        else pass_cnt++;
    endtask

    task automatic test_bypass;
        logic [31:0] exp_same;
        drive_fire(1'b1, 1'b0, 5'd7, 3'b010, 32'h1111_1111, 32'h0);
        @(negedge clk);
        valid_wb    = 1'b1;
        ready_go_wb = 1'b1;
        write_reg   = 1'b1;
        mem2reg     = 1'b0;
        rd_wb       = 5'd7;
        mem_address = 32'hA5A5_A5A5;
        rs2_addr    = 5'd7;
        rs1_addr    = 5'd5;
`ifdef WB_REGFILE_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h1111_1111;
`endif
        #1;
        chk_cnt++;
        if (rs2_data !== exp_same) $display("FAIL bypass_same_cycle: got %h expected %h", rs2_data, exp_same);
        else pass_cnt++;
        chk_cnt++;
        if (rs1_data !== 32'h1234_5678) $display("FAIL bypass_other_port: got %h expected 12345678", rs1_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        valid_wb = 1'b0;
        #1;
        chk_cnt++;
        if (rs2_data !== 32'hA5A5_A5A5) $display("FAIL bypass_next_cycle: got %h expected a5a5a5a5", rs2_data);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd9) $display("FAIL bypass_instret: got %0d expected 9", instret);
        else pass_cnt++;
    endtask

    task automatic test_misalign;
        @(negedge clk);
        valid_wb      = 1'b1;
        ready_go_wb   = 1'b1;
        write_reg     = 1'b1;
        mem2reg       = 1'b1;
        rd_wb         = 5'd9;
        ins_func3     = 3'b010;
        mem_address   = 32'h0000_1002;
        mem_read_data = 32'hCAFE_F00D;
        rs1_addr      = 5'd9;
        // Upstream keeps presenting the instruction while the trap is pending.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk_cnt++;
            if (misalign_err !== 1'b1) $display("FAIL misalign_err[%0d]: got %b expected 1", c, misalign_err);
            else pass_cnt++;
            chk_cnt++;
            if (err_addr !== 32'h0000_1002) $display("FAIL misalign_addr[%0d]: got %h expected 00001002", c, err_addr);
            else pass_cnt++;
            chk_cnt++;
            if (allow_in_regfile !== 1'b0) $display("FAIL misalign_allow[%0d]: got %b expected 0", c, allow_in_regfile);
            else pass_cnt++;
            chk_cnt++;
            if (instret !== 64'd9) $display("FAIL misalign_instret[%0d]: got %0d expected 9", c, instret);
            else pass_cnt++;
            chk_cnt++;
            if (rs1_data !== 32'h0) $display("FAIL misalign_nowrite[%0d]: got %h expected 0", c, rs1_data);
            else pass_cnt++;
        end
        @(negedge clk);
        valid_wb = 1'b0;
        err_ack  = 1'b1;
        @(posedge clk);
        #1;
        err_ack = 1'b0;
        chk_cnt++;
        if (allow_in_regfile !== 1'b1) $display("FAIL ack_allow: got %b expected 1", allow_in_regfile);
        else pass_cnt++;
        chk_cnt++;
        if (misalign_err !== 1'b0) $display("FAIL ack_misalign: got %b expected 0", misalign_err);
        else pass_cnt++;
        chk_cnt++;
        if (err_addr !== 32'h0000_1002) $display("FAIL ack_err_addr_hold: got %h expected 00001002", err_addr);
        else pass_cnt++;
        // err_ack in RUN must not disturb anything; a following ALU op commits normally.
        @(negedge clk);
        err_ack = 1'b1;
        @(posedge clk);
        #1;
        err_ack = 1'b0;
        chk_cnt++;
        if (allow_in_regfile !== 1'b1 || misalign_err !== 1'b0)
            $display("FAIL ack_in_run: got allow=%b err=%b expected allow=1 err=0", allow_in_regfile, misalign_err);
        else pass_cnt++;
        drive_fire(1'b1, 1'b0, 5'd9, 3'b010, 32'h0BAD_F00D, 32'h0);
        #1;
        chk_cnt++;
        if (rs1_data !== 32'h0BAD_F00D) $display("FAIL post_trap_write: got %h expected 0badf00d", rs1_data);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd10) $display("FAIL post_trap_instret: got %0d expected 10", instret);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_err;
        // Misaligned LH at an odd address traps; reset then clears everything in one cycle.
        drive_fire(1'b1, 1'b1, 5'd3, 3'b001, 32'h0000_3001, 32'h1234_5678);
        chk_cnt++;
        if (misalign_err !== 1'b1 || err_addr !== 32'h0000_3001)
            $display("FAIL lh_trap: got err=%b addr=%h expected err=1 addr=00003001", misalign_err, err_addr);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd9;
        #1;
        chk_cnt++;
        if (allow_in_regfile !== 1'b1 || misalign_err !== 1'b0 || err_addr !== 32'h0)
            $display("FAIL rst_in_err: got allow=%b err=%b addr=%h expected 1 0 0", allow_in_regfile, misalign_err, err_addr);
        else pass_cnt++;
        chk_cnt++;
        if (instret !== 64'd0) $display("FAIL rst_in_err_instret: got %0d expected 0", instret);
        else pass_cnt++;
        chk_cnt++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
            $display("FAIL rst_in_err_regs: got %h %h expected 0 0", rs1_data, rs2_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        valid_wb      = 1'b0;
        ready_go_wb   = 1'b0;
        write_reg     = 1'b0;
        mem2reg       = 1'b0;
        rd_wb         = '0;
        ins_func3     = '0;
        mem_address   = '0;
        mem_read_data = '0;
        rs1_addr      = '0;
        rs2_addr      = '0;
        err_ack       = 1'b0;
        test_reset;
        test_alu_write;
        test_loads;
        test_x0_gating;
        test_bypass;
        test_misalign;
        test_reset_in_err;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
